// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard scoreboard.
package fwd_pkg;

    // Widest register address the entry struct can carry; AW must not exceed it.
    localparam int MAX_AW = 8;

    // Architectural register numbers with special forwarding behaviour.
    localparam int ZERO_REG = 31;
    localparam int LINK_REG = 30;

    // One in-flight writer: bubble flag, destination, write enable, load flag.
    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] rd;
        logic              wen;
        logic              load;
    } sb_entry_t;

    // Width of a forward select covering register file plus DEPTH stages.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority encoder: picks the youngest in-flight producer.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int AW    = 5,
    parameter int ZREG  = 31,
    parameter int SW    = sel_width(DEPTH)
) (
    input  sb_entry_t [DEPTH:1] entries,
    input  logic [AW-1:0]       src_addr,
    input  logic                src_used,
    output logic [SW-1:0]       sel,
    output logic                hit_is_load_stage1
);

    logic found;

    // Scan from stage 1 outward; the first matching stage is the youngest writer.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path infers a latch.
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found && src_used &&
                entries[k].valid && entries[k].wen &&
                entries[k].rd == MAX_AW'(src_addr) &&
                entries[k].rd != MAX_AW'(ZREG)) begin
                sel   = SW'(k);
                found = 1'b1;
            end
        end
        // A load still in EX has no data yet; only this case forces a stall.
        hit_is_load_stage1 = (sel == SW'(1)) && entries[1].load;
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit between ID and the EX operand muxes.
module fwd_scoreboard #(
    parameter int AW       = 5,
    parameter int NSRC     = 3,
    parameter int DEPTH    = 3,
    parameter int ZERO_REG = fwd_pkg::ZERO_REG,
    parameter int LINK_REG = fwd_pkg::LINK_REG,
    parameter int CW       = 16,
    // Derived from DEPTH; leave at its default.
    parameter int SW       = fwd_pkg::sel_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_rd,
    input  logic                     issue_wen,
    input  logic                     issue_load,
    input  logic                     issue_link,
    input  logic                     flush,
    input  logic [NSRC-1:0][AW-1:0]  src_addr,
    input  logic [NSRC-1:0]          src_used,
    output logic [NSRC-1:0][SW-1:0]  fwd_sel,
    output logic                     stall,
    output logic [CW-1:0]            stall_cnt,
    output logic [CW-1:0]            fwd_cnt
);

    import fwd_pkg::*;

    sb_entry_t [DEPTH:1] sb_q, sb_d;
    logic [NSRC-1:0]     load_hit;
    logic                fwd_any;
    logic [CW-1:0]       stall_cnt_q, stall_cnt_d;
    logic [CW-1:0]       fwd_cnt_q, fwd_cnt_d;

    // One priority encoder per source operand.
    for (genvar s = 0; s < NSRC; s++) begin : g_src
        fwd_match #(
            .DEPTH (DEPTH),
            .AW    (AW),
            .ZREG  (ZERO_REG),
            .SW    (SW)
        ) u_match (
            .entries            (sb_q),
            .src_addr           (src_addr[s]),
            .src_used           (src_used[s]),
            .sel                (fwd_sel[s]),
            .hit_is_load_stage1 (load_hit[s])
        );
    end

    assign stall   = |load_hit;
    assign fwd_any = |fwd_sel;

    // Next scoreboard: shift older stages, then admit ID or insert a bubble.
    always_comb begin
        sb_d = sb_q;
        for (int k = DEPTH; k >= 2; k--) begin
            sb_d[k] = sb_q[k-1];
        end
        sb_d[1] = '0;
        // Flush and stall both reject the ID instruction; a bubble enters EX.
        if (issue_valid && !stall && !flush) begin
            sb_d[1].valid = 1'b1;
            sb_d[1].rd    = issue_link ? MAX_AW'(LINK_REG) : MAX_AW'(issue_rd);
            sb_d[1].wen   = issue_wen | issue_link;
            sb_d[1].load  = issue_load;
        end
    end

    // Saturating hazard statistics; a stalled cycle never counts as a forward.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
        if (fwd_any && !stall && fwd_cnt_q != '1) begin
            fwd_cnt_d = fwd_cnt_q + CW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            // NOTE: only the valid bits are cleared; payload of an invalid entry is never looked at.
            for (int k = 1; k <= DEPTH; k++) begin
                sb_q[k].valid <= 1'b0;
            end
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule
